hdlc_rx_deframer: RTL and testbench

Receive-side HDLC deframer. It sits directly downstream of the receive bit synchroniser and upstream of the receive FCS checker and receive buffer. It consumes the serial Rx bit stream and performs flag hunting, zero-bit removal and abort detection. It delivers de-stuffed octets with frame start, end and error markers.

---
 rtl/hdlc_rx_deframer.sv | 216 +++++++++++++++++++++
 tb/tb_hdlc_rx_deframer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: receive-side HDLC deframer.
// Performs flag hunting, zero-bit removal and abort detection on the serial
// Rx stream and delivers de-stuffed octets with frame start/end/error marks.
//
// Ports:
//   RxClk        receive bit clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   RxEN         bit-valid strobe, Rx is sampled only when high
//   Rx           serial receive bit, LSB first
//   RxData       assembled octet, valid with RxValid
//   RxValid      one-cycle pulse per delivered octet
//   RxSOF        pulses with RxValid of the first octet of a frame
//   RxEOF        pulse on the closing flag of a frame that delivered octets
//   RxFrameError pulse on non-octet end, short frame or overflow
//   AbortSignal  pulse on abort inside a frame
//   ZeroRemoved  pulse per discarded stuffed zero
module hdlc_rx_deframer #(
    parameter int unsigned MAX_BYTES = 128,
    parameter int unsigned MIN_BYTES = 4
) (
    input  logic       RxClk,
    input  logic       rst,
    input  logic       RxEN,
    input  logic       Rx,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       RxSOF,
    output logic       RxEOF,
    output logic       RxFrameError,
    output logic       AbortSignal,
    output logic       ZeroRemoved
);

    localparam int unsigned ONES_W     = 3;
    localparam int unsigned DL_LEN     = 7;
    localparam int unsigned DL_CNT_W   = 3;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned BYTE_CNT_W = 8;
    localparam int unsigned OCTET_W    = 8;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic [ONES_W-1:0]       ones_q,     ones_d;
    logic [DL_LEN-1:0]       dl_q,       dl_d;
    logic [DL_CNT_W-1:0]     dl_cnt_q,   dl_cnt_d;
    logic [OCTET_W-1:0]      shift_q,    shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [OCTET_W-1:0]      data_q,     data_d;
    logic                    valid_q,    valid_d;
    logic                    sof_q,      sof_d;
    logic                    eof_q,      eof_d;
    logic                    err_q,      err_d;
    logic                    abort_q,    abort_d;
    logic                    zr_q,       zr_d;

    logic is_flag;
    logic is_stuff;
    logic is_abort;
    logic accept;
    logic pop;
    logic deliver;
    logic overflow;
    logic flush;

    // State and output registers.
    always_ff @(posedge RxClk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_HUNT;
            ones_q     <= '0;
            dl_q       <= '0;
            dl_cnt_q   <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            zr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ones_q     <= ones_d;
            dl_q       <= dl_d;
            dl_cnt_q   <= dl_cnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            zr_q       <= zr_d;
        end
    end

    // Per-bit line decode, delay line, octet assembly and frame state.
    always_comb begin
        state_d    = state_q;
        ones_d     = ones_q;
        dl_d       = dl_q;
        dl_cnt_d   = dl_cnt_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        err_d      = 1'b0;
        abort_d    = 1'b0;
        zr_d       = 1'b0;
        is_flag    = 1'b0;
        is_stuff   = 1'b0;
        is_abort   = 1'b0;
        accept     = 1'b0;
        pop        = 1'b0;
        deliver    = 1'b0;
        overflow   = 1'b0;
        flush      = 1'b0;

        if (RxEN) begin
            is_flag  = !Rx && (ones_q == ONES_W'(6));
            is_stuff = !Rx && (ones_q == ONES_W'(5));
            is_abort =  Rx && (ones_q == ONES_W'(6));

            if (Rx) begin
                ones_d = (ones_q == ONES_W'(7)) ? ones_q : ones_q + ONES_W'(1);
            end else begin
                ones_d = '0;
            end

            if (state_q == ST_HUNT) begin
                if (is_flag) begin
                    state_d = ST_OPEN;
                end
            end else begin
                // The abort bit itself is accepted so it can push out the
                // last bit of an octet that ended just before the abort.
                accept = !is_flag && !is_stuff;
                zr_d   = is_stuff;
                pop    = accept && (dl_cnt_q == DL_CNT_W'(DL_LEN));

                if (accept) begin
                    dl_d = {dl_q[DL_LEN-2:0], Rx};
                    if (!pop) begin
                        dl_cnt_d = dl_cnt_q + DL_CNT_W'(1);
                    end
                end

                if (pop) begin
                    shift_d = {dl_q[DL_LEN-1], shift_q[OCTET_W-1:1]};
                    if (bit_cnt_q == BIT_CNT_W'(7)) begin
                        bit_cnt_d = '0;
                        if (byte_cnt_q == BYTE_CNT_W'(MAX_BYTES)) begin
                            overflow = 1'b1;
                        end else begin
                            deliver    = 1'b1;
                            data_d     = {dl_q[DL_LEN-1], shift_q[OCTET_W-1:1]};
                            valid_d    = 1'b1;
                            sof_d      = (state_q == ST_OPEN);
                            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                            state_d    = ST_FRAME;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end

                if (overflow) begin
                    err_d   = 1'b1;
                    state_d = ST_HUNT;
                    flush   = 1'b1;
                end else if (is_flag) begin
                    // Closing flag doubles as the opening flag of the next frame.
                    if (state_q == ST_FRAME) begin
                        eof_d = 1'b1;
                        err_d = (bit_cnt_q != '0) ||
                                (byte_cnt_q < BYTE_CNT_W'(MIN_BYTES));
                    end
                    state_d = ST_OPEN;
                    flush   = 1'b1;
                end else if (is_abort) begin
                    // An octet completed on the abort bit still counts as in-frame.
                    abort_d = (state_q == ST_FRAME) || deliver;
                    state_d = ST_HUNT;
                    flush   = 1'b1;
                end
            end
        end

        if (flush) begin
            dl_cnt_d   = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end
    end

    assign RxData       = data_q;
    assign RxValid      = valid_q;
    assign RxSOF        = sof_q;
    assign RxEOF        = eof_q;
    assign RxFrameError = err_q;
    assign AbortSignal  = abort_q;
    assign ZeroRemoved  = zr_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb_hdlc_rx_deframer: directed self-checking bench for hdlc_rx_deframer.
// A transmit-side model stuffs zeros and builds flags; a negedge monitor
// records delivered octets and event pulses for comparison.
module tb_hdlc_rx_deframer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_en = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sof;
    logic       rx_eof;
    logic       rx_frame_error;
    logic       abort_signal;
    logic       zero_removed;

    always #5 clk = ~clk;

    hdlc_rx_deframer #(
        .MAX_BYTES (128),
        .MIN_BYTES (4)
    ) dut (
        .RxClk        (clk),
        .rst          (rst_n),
        .RxEN         (rx_en),
        .Rx           (rx),
        .RxData       (rx_data),
        .RxValid      (rx_valid),
        .RxSOF        (rx_sof),
        .RxEOF        (rx_eof),
        .RxFrameError (rx_frame_error),
        .AbortSignal  (abort_signal),
        .ZeroRemoved  (zero_removed)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int gap      = 0;
    int tx_ones  = 0;

    // Monitor state.
    logic [7:0] mon_data[$];
    logic       mon_sof[$];
    int n_sof   = 0;
    int n_eof   = 0;
    int n_err   = 0;
    int n_abort = 0;
    int n_zr    = 0;
    int n_clash = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                mon_data.push_back(rx_data);
                mon_sof.push_back(rx_sof);
            end
            if (rx_sof)         n_sof++;
            if (rx_eof)         n_eof++;
            if (rx_frame_error) n_err++;
            if (abort_signal)   n_abort++;
            if (zero_removed)   n_zr++;
            if (rx_valid && rx_eof) n_clash++;
        end
    end

    task automatic clr_mon();
        mon_data.delete();
        mon_sof.delete();
        n_sof   = 0;
        n_eof   = 0;
        n_err   = 0;
        n_abort = 0;
        n_zr    = 0;
    endtask

    function automatic logic [31:0] first4();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < mon_data.size()) r[i*8 +: 8] = mon_data[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] sof4();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < mon_sof.size()) r[i] = mon_sof[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] last_data();
        logic [31:0] r;
        r = '0;
        if (mon_data.size() > 0) r[7:0] = mon_data[mon_data.size()-1];
        return r;
    endfunction

    // One sampled bit, followed by 'gap' cycles with the strobe low.
    task automatic send_bit(input logic b);
        rx    = b;
        rx_en = 1'b1;
        @(posedge clk);
        #1;
        rx_en = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i]);
        tx_ones = 0;
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
        tx_ones = 0;
    endtask

    // Data octet with transmit-side zero insertion after five ones.
    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            if (b[i]) tx_ones++;
            else      tx_ones = 0;
            if (tx_ones == 5) begin
                send_bit(1'b0);
                tx_ones = 0;
            end
        end
    endtask

    task automatic send_std_frame();
        send_flag();
        for (int k = 1; k <= 4; k++) send_byte(8'(k));
        send_flag();
    endtask

    task automatic settle();
        rx_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic separate();
        send_ones(16);
        settle();
        clr_mon();
    endtask

    initial begin
        logic [14:0] pat;
        pat = 15'b011111101111110;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {24'd0, rx_data} | {25'd0, rx_valid, rx_sof, rx_eof, rx_frame_error,
                                  abort_signal, zero_removed, 1'b0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic four-octet frame.
        separate();
        send_std_frame();
        settle();
        check("basic_count", mon_data.size(), 4);
        check("basic_data",  first4(), 32'h04030201);
        check("basic_sof",   sof4(), 32'h1);
        check("basic_eof",   n_eof, 1);
        check("basic_err",   n_err, 0);
        check("basic_zr",    n_zr, 0);

        // Stuffed zeros and a repeated closing flag.
        separate();
        send_flag();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_flag();
        send_flag();
        settle();
        check("stuff_zr",    n_zr, 3);
        check("stuff_count", mon_data.size(), 4);
        check("stuff_data",  first4(), 32'hAA00FFFF);
        check("stuff_eof",   n_eof, 1);
        check("stuff_err",   n_err, 0);

        // Abort inside a frame, then continuous ones.
        separate();
        send_flag();
        send_byte(8'h55);
        send_ones(8);
        send_ones(16);
        settle();
        check("abort_count", mon_data.size(), 1);
        check("abort_data",  first4(), 32'h55);
        check("abort_sof",   n_sof, 1);
        check("abort_pulse", n_abort, 1);
        check("abort_eof",   n_eof, 0);
        clr_mon();
        send_std_frame();
        settle();
        check("post_abort_data",  first4(), 32'h04030201);
        check("post_abort_eof",   n_eof, 1);
        check("post_abort_abort", n_abort, 0);
        check("post_abort_err",   n_err, 0);

        // Non-octet-aligned end.
        separate();
        send_flag();
        for (int k = 1; k <= 4; k++) send_byte(8'(k));
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_flag();
        settle();
        check("align_count", mon_data.size(), 4);
        check("align_eof",   n_eof, 1);
        check("align_err",   n_err, 1);

        // Short frame.
        separate();
        send_flag();
        send_byte(8'h01);
        send_byte(8'h02);
        send_flag();
        settle();
        check("short_count", mon_data.size(), 2);
        check("short_eof",   n_eof, 1);
        check("short_err",   n_err, 1);

        // Shared-zero flags, then an over-length frame.
        separate();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 15; i++) send_bit(pat[i]);
        end
        tx_ones = 0;
        settle();
        check("flags_valid", mon_data.size(), 0);
        check("flags_sof",   n_sof, 0);
        check("flags_eof",   n_eof, 0);
        for (int k = 0; k <= 128; k++) send_byte(8'(k));
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        send_ones(8);
        settle();
        check("ovf_count", mon_data.size(), 128);
        check("ovf_first", first4(), 32'h03020100);
        check("ovf_last",  last_data(), 32'h7F);
        check("ovf_sof",   n_sof, 1);
        check("ovf_err",   n_err, 1);
        check("ovf_eof",   n_eof, 0);
        check("ovf_hunt_abort", n_abort, 0);

        // Sparse strobe: one sampled bit every three cycles.
        separate();
        gap = 2;
        send_std_frame();
        settle();
        gap = 0;
        check("gap_count", mon_data.size(), 4);
        check("gap_data",  first4(), 32'h04030201);
        check("gap_sof",   sof4(), 32'h1);
        check("gap_eof",   n_eof, 1);
        check("gap_err",   n_err, 0);

        // Reset mid-frame.
        separate();
        send_flag();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        settle();
        check("midrst_count", mon_data.size(), 2);
        rst_n = 1'b0;
        #2;
        check("midrst_outputs",
              {24'd0, rx_data} | {25'd0, rx_valid, rx_sof, rx_eof, rx_frame_error,
                                  abort_signal, zero_removed, 1'b0}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr_mon();
        tx_ones = 0;
        send_byte(8'h04);
        send_flag();
        settle();
        check("midrst_tail_valid", mon_data.size(), 0);
        check("midrst_tail_eof",   n_eof, 0);
        for (int k = 1; k <= 4; k++) send_byte(8'(k));
        send_flag();
        settle();
        check("midrst_next_data", first4(), 32'h04030201);
        check("midrst_next_eof",  n_eof, 1);
        check("midrst_next_sof",  n_sof, 1);

        check("valid_eof_clash", n_clash, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
